// File: rtl/ps2_host_tx_if.sv
// Command and pin-level signal bundle for the PS/2 host-to-device transmitter.
// master = command source / pin environment, slave = the transmitter.
interface ps2_host_tx_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;

  modport master (
    output cmd_valid, cmd_data, ps2_clk_in, ps2_dat_in,
    input  cmd_ready, ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout
  );

  modport slave (
    input  cmd_valid, cmd_data, ps2_clk_in, ps2_dat_in,
    output cmd_ready, ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, device-clocked frame shift, ACK check.
// Optional macro PS2_TX_RETRY_EN: one automatic retry after an ACK error or timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int RTS_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         reset,
  ps2_host_tx_if.slave bus
);

  localparam int MAX_AB = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int MAX_C  = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int CNT_W  = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       STOP_IDX = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [9:0]       frame_q, frame_d;
  logic             dat_q, dat_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic             timeout_q, timeout_d;
`ifdef PS2_TX_RETRY_EN
  logic             retry_q, retry_d;
`endif

  logic clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
  logic fe, fail_ack, fail_tmo;

  // Stage: pin synchronisers; idle lines are high so reset to 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= bus.ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= bus.ps2_dat_in;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fe = clk_prev_q & ~clk_s2_q;

  // Stage: control state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      timeout_q <= timeout_d;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  // Stage: frame payload, only meaningful once a command is accepted
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
    dat_q   <= dat_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    dat_d     = dat_q;
    done_d    = 1'b0;
    ack_err_d = 1'b0;
    timeout_d = 1'b0;
    fail_ack  = 1'b0;
    fail_tmo  = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.cmd_valid) begin
          frame_d = {1'b1, ~^bus.cmd_data, bus.cmd_data};
          state_d = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d = 1'b0;
`endif
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          state_d = S_RTS;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RTS: begin
        if (cnt_q == RTS_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          dat_d   = 1'b1;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_SEND, S_ACK, S_WAIT_IDLE: begin
        // A silent device wins over an edge arriving on the expiry cycle
        if (cnt_q == TMO_LAST) begin
          fail_tmo = 1'b1;
        end else begin
          cnt_d = fe ? '0 : cnt_q + CNT_ONE;
          if (state_q == S_SEND) begin
            if (fe) begin
              dat_d = ~frame_q[bit_q];
              bit_d = bit_q + 4'd1;
              if (bit_q == STOP_IDX) state_d = S_ACK;
            end
          end else if (state_q == S_ACK) begin
            if (fe) begin
              if (dat_s2_q) fail_ack = 1'b1;
              else          state_d  = S_WAIT_IDLE;
            end
          end else if (clk_s2_q && dat_s2_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fail_ack || fail_tmo) begin
      cnt_d = '0;
`ifdef PS2_TX_RETRY_EN
      if (!retry_q) begin
        retry_d = 1'b1;
        state_d = S_INHIBIT;
      end else begin
        ack_err_d = fail_ack;
        timeout_d = fail_tmo;
        state_d   = S_IDLE;
      end
`else
      ack_err_d = fail_ack;
      timeout_d = fail_tmo;
      state_d   = S_IDLE;
`endif
    end
  end

  // Line drives decode straight from state so reset releases them at once
  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.ps2_clk_oe = (state_q == S_INHIBIT) || (state_q == S_RTS);
  assign bus.ps2_dat_oe = (state_q == S_RTS) || ((state_q == S_SEND) && dat_q);
  assign bus.done       = done_q;
  assign bus.ack_err    = ack_err_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed + randomized bench for ps2_host_tx with a behavioural PS/2 device on wired-AND lines.
module tb_ps2_host_tx;
  localparam int INH = 60;
  localparam int RTS = 8;
  localparam int TMO = 400;

  logic clk = 1'b0;
  logic reset;
  logic dev_clk, dev_dat;
  int   H = 10;
  int   passed = 0, total = 0;
  int   n_done = 0, n_ack = 0, n_tmo = 0;
  int   s_d, s_a, s_t;
  logic last_busy = 1'b1, last_ready = 1'b0;

  always #5 clk = ~clk;

  ps2_host_tx_if bus();

  assign bus.ps2_clk_in = ~bus.ps2_clk_oe & dev_clk;
  assign bus.ps2_dat_in = ~bus.ps2_dat_oe & dev_dat;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES    (RTS),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Pulse monitor: counts status pulses and what busy/ready looked like alongside them
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      n_done <= n_done + 1; last_busy <= bus.busy; last_ready <= bus.cmd_ready;
    end
    if (bus.ack_err === 1'b1) begin
      n_ack <= n_ack + 1; last_busy <= bus.busy; last_ready <= bus.cmd_ready;
    end
    if (bus.timeout === 1'b1) begin
      n_tmo <= n_tmo + 1; last_busy <= bus.busy; last_ready <= bus.cmd_ready;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference frame: data LSB first, odd parity, stop bit
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    s_d = n_done; s_a = n_ack; s_t = n_tmo;
  endtask

  task automatic start_cmd(input logic [7:0] b);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = b;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
  endtask

  task automatic phases(input string tag);
    int n = 0;
    while (bus.ps2_clk_oe === 1'b1 && bus.ps2_dat_oe === 1'b0 && n < 4 * INH) begin
      n++; @(negedge clk);
    end
    chk({tag, "_inhibit_len"}, n, INH);
    n = 0;
    while (bus.ps2_clk_oe === 1'b1 && bus.ps2_dat_oe === 1'b1 && n < 4 * RTS) begin
      n++; @(negedge clk);
    end
    chk({tag, "_rts_len"}, n, RTS);
    chk({tag, "_start_bit"}, {bus.ps2_clk_oe, bus.ps2_dat_oe, bus.busy, bus.cmd_ready}, 4'b0110);
  endtask

  // Device side: 10 clock pulses reading data while high, then an 11th for the ACK slot
  task automatic dev_frame(input logic ack_lo, input int inj, input int rk,
                           output logic [9:0] bits, output bit aborted);
    aborted = 1'b0;
    bits    = '0;
    cyc(H);
    for (int k = 0; k < 10; k++) begin
      dev_clk = 1'b0;
      cyc(H);
      if (k == rk) begin
        chk("rst_pre_dat_oe", bus.ps2_dat_oe, 1'b1);
        reset = 1'b1;
        #1;
        chk("rst_async_lines", {bus.ps2_clk_oe, bus.ps2_dat_oe, bus.busy, bus.cmd_ready}, 4'b0001);
        dev_clk = 1'b1;
        aborted = 1'b1;
        return;
      end
      if (k == inj) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'hAA;
      end
      dev_clk = 1'b1;
      cyc(H / 2);
      bits[k] = bus.ps2_dat_in;
      cyc(H - H / 2);
      if (k == inj) begin
        chk("busy_cmd_ready", bus.cmd_ready, 1'b0);
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
      end
    end
    if (ack_lo) dev_dat = 1'b0;
    cyc(2);
    dev_clk = 1'b0;
    cyc(H);
    dev_clk = 1'b1;
    cyc(H / 2);
    dev_dat = 1'b1;
    cyc(H - H / 2);
  endtask

  task automatic outcome(input string tag, input int ed, input int ea, input int et);
    int g = 0;
    while ((n_done + n_ack + n_tmo) == (s_d + s_a + s_t) && g < 300) begin
      @(negedge clk); g++;
    end
    cyc(6);
    chk({tag, "_done_cnt"}, n_done - s_d, ed);
    chk({tag, "_ackerr_cnt"}, n_ack - s_a, ea);
    chk({tag, "_timeout_cnt"}, n_tmo - s_t, et);
    chk({tag, "_busy_ready_at_pulse"}, {last_busy, last_ready}, 2'b01);
    chk({tag, "_idle"}, {bus.busy, bus.cmd_ready, bus.ps2_clk_oe, bus.ps2_dat_oe}, 4'b0100);
  endtask

  task automatic xfer(input string tag, input logic [7:0] b, input logic ack_lo, input int inj);
    logic [9:0] bits;
    bit         ab;
    snap();
    chk({tag, "_ready_before"}, bus.cmd_ready, 1'b1);
    start_cmd(b);
    phases(tag);
    dev_frame(ack_lo, inj, -1, bits, ab);
    chk({tag, "_frame"}, bits, model_frame(b));
`ifdef PS2_TX_RETRY_EN
    if (!ack_lo) begin
      phases({tag, "_retry"});
      dev_frame(ack_lo, -1, -1, bits, ab);
      chk({tag, "_retry_frame"}, bits, model_frame(b));
    end
`endif
    outcome(tag, ack_lo ? 1 : 0, ack_lo ? 0 : 1, 0);
  endtask

  initial begin
    int         n;
    int         exp_n;
    logic [9:0] bits;
    bit         ab;
    logic [7:0] rb;
    logic       rack;

    reset         = 1'b1;
    dev_clk       = 1'b1;
    dev_dat       = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    cyc(3);
    chk("reset_state", {bus.busy, bus.cmd_ready, bus.ps2_clk_oe, bus.ps2_dat_oe,
                        bus.done, bus.ack_err, bus.timeout}, 7'b0100000);
    reset = 1'b0;
    cyc(3);

    xfer("ed", 8'hED, 1'b1, -1);
    xfer("x00", 8'h00, 1'b1, -1);
    xfer("x01", 8'h01, 1'b1, -1);
    xfer("f4_nak", 8'hF4, 1'b0, -1);

    // Device never clocks after the request-to-send
    snap();
    start_cmd(8'h55);
    phases("tmo");
    n = 0;
`ifdef PS2_TX_RETRY_EN
    exp_n = 2 * TMO + INH + RTS;
`else
    exp_n = TMO;
`endif
    while (bus.timeout !== 1'b1 && n < 3 * TMO + INH + RTS) begin
      @(negedge clk); n++;
    end
    chk("tmo_latency", n, exp_n);
    outcome("tmo", 0, 0, 1);

    xfer("busy_ignore", 8'h3C, 1'b1, 4);

    // Reset in the middle of the frame
    snap();
    start_cmd(8'h3C);
    phases("rst");
    dev_frame(1'b1, -1, 6, bits, ab);
    cyc(3);
    reset = 1'b0;
    cyc(10);
    chk("rst_no_pulses", (n_done - s_d) + (n_ack - s_a) + (n_tmo - s_t), 0);
    chk("rst_idle", {bus.busy, bus.cmd_ready, bus.ps2_clk_oe, bus.ps2_dat_oe}, 4'b0100);
    xfer("ff_after_rst", 8'hFF, 1'b1, -1);

    for (int i = 0; i < 4; i++) begin
      H    = int'($urandom_range(8, 14));
      rb   = 8'($urandom);
      rack = 1'($urandom_range(0, 3) != 0);
      xfer("rnd", rb, rack, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
